// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and constants for the fetch/data RAM port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEFAULT_MEM_LAT = 2;
  // Wide enough for the largest legal read latency (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for the two requesters plus the RAM macro pins.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_done;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin choice; a tie goes to the port that did not own the RAM last.
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic   f_req_i,
  input  logic   d_req_i,
  input  owner_t last_owner_i,
  output logic   pick_vld_o,
  output owner_t pick_owner_o
);

  always_comb begin
    pick_vld_o   = f_req_i | d_req_i;
    pick_owner_o = OWN_F;
    if (f_req_i && d_req_i) begin
      pick_owner_o = (last_owner_i == OWN_F) ? OWN_D : OWN_F;
    end else if (d_req_i) begin
      pick_owner_o = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and load/store; read done at MEM_LAT+2 cycles, write at 2.
// Requesters hold req until done; reqs are only looked at in IDLE, so a busy RAM simply stalls them.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              f_gnt_q, f_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              f_done_q, f_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;

  logic   pick_vld;
  owner_t pick_owner;

  mem_port_arbiter_rr_pick2 u_pick (
    .f_req_i      (bus.f_req),
    .d_req_i      (bus.d_req),
    .last_owner_i (last_q),
    .pick_vld_o   (pick_vld),
    .pick_owner_o (pick_owner)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_owner;
          state_d = ACCESS;
          if (pick_owner == OWN_D) begin
            we_d        = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            we_d       = 1'b0;
            mem_addr_d = bus.f_addr;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(MEM_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // mem_rdata is valid exactly MEM_LAT cycles after the ACCESS strobe.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          if (owner_q == OWN_F) f_rdata_d = bus.mem_rdata;
          else                  d_rdata_d = bus.mem_rdata;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    busy_d   = (state_d != IDLE);
    mem_en_d = (state_d == ACCESS);
    mem_we_d = (state_d == ACCESS) && we_d;
    f_gnt_d  = busy_d && (owner_d == OWN_F);
    d_gnt_d  = busy_d && (owner_d == OWN_D);
    f_done_d = (state_d == DONE) && (owner_d == OWN_F);
    d_done_d = (state_d == DONE) && (owner_d == OWN_D);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_F;
      last_q      <= OWN_D;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      f_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      f_gnt_q     <= f_gnt_d;
      d_gnt_q     <= d_gnt_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.f_gnt     = f_gnt_q;
  assign bus.f_done    = f_done_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data RAM between the instruction-fetch path (IR load during FETCH microsteps) and the load/store path (execute microsteps).
- Two-way round-robin arbiter with a per-port req/gnt/done handshake.
- Drives the RAM enable, address and write strobe, and waits a fixed read latency before returning data.
- Sits between the control sequencer and the memory macro.

Parameters:
- ADDR_W, 8, address width on both request ports and on the RAM.
- DATA_W, 8, data width.
- MEM_LAT, 2, read latency of the RAM in cycles from mem_en to valid mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; level signal, held until f_done.
- f_addr  in  ADDR_W  fetch address.
- f_gnt  out  1  fetch port owns the RAM.
- f_done  out  1  one-cycle pulse; f_rdata is valid.
- f_rdata  out  DATA_W  fetched word; held until the next f_done.
- d_req  in  1  data request; level signal, held until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data port owns the RAM.
- d_done  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  read word; held until the next d_done of a read.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs are 0, state is IDLE, last_owner is DATA (so fetch wins the first tie), wait counter is 0.
- Reset is asynchronous. Asserting it mid-access abandons the access: no done pulse, mem_en/mem_we drop immediately.
- States: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- IDLE:
  - req inputs are sampled only in IDLE.
  - Only one req high: grant that port.
  - Both high: grant the port that is not last_owner.
  - On grant: latch owner, we (forced 0 for fetch), addr and wdata. Go to ACCESS.
- ACCESS (one cycle):
  - mem_en=1, mem_addr/mem_wdata = latched values, mem_we = latched we.
  - Owner's gnt=1.
  - Write goes to DONE. Read goes to WAIT with counter=MEM_LAT.
- WAIT:
  - mem_en=0; gnt stays high.
  - Counter decrements each cycle.
  - On the last WAIT cycle (counter==1), mem_rdata is captured into the owner's rdata register at the clock edge. Then go to DONE.
- DONE (one cycle):
  - Owner's done=1, gnt=1, last_owner=owner.
  - Next state is always IDLE.
- Timing from req sampled in cycle 0:
  - ACCESS in cycle 1.
  - Read: done in cycle MEM_LAT+2.
  - Write: done in cycle 2.
  - A new grant can issue no earlier than ACCESS in cycle DONE+2.
- Requester rule: deassert req at the edge that samples done. A req still high in the following IDLE cycle is a new access.
- Address/data stability: mem_addr and mem_wdata hold their last driven values outside ACCESS. mem_we is high only in ACCESS. The non-owner's gnt and done stay 0 throughout.
- Changes to addr/wdata/we after grant are ignored.
- d_rdata is unchanged by writes. f_rdata and d_rdata are updated only by their own port's reads.
- Starvation bound: with both reqs held continuously, grants strictly alternate F, D, F, D.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3.
  - Owner encoding: OWN_F=1'b0, OWN_D=1'b1.
  - Default MEM_LAT constant.
- Sub-module rr_pick2: combinational 2-way round-robin choice from (f_req, d_req, last_owner). The FSM, latency counter and data registers stay in the top module.

Test Plan:
- MEM_LAT=2, fetch read: f_req in cycle 0, f_addr=0x10, RAM returns 0xA5 -> mem_en=1 and mem_addr=0x10 in cycle 1; f_done in cycle 4; f_rdata=0xA5; d_gnt never asserts.
- Data write: d_req, d_we=1, d_addr=0x20, d_wdata=0x3C -> mem_en=mem_we=1 in cycle 1 with 0x20/0x3C; d_done in cycle 2; d_rdata unchanged; mem_we=0 in all other cycles.
- Tie after reset: f_req and d_req both rise in cycle 0 -> fetch granted first (f_done cycle 4); data ACCESS in cycle 6; d_done cycle 9 for a read.
- Both reqs held for 4 transactions -> grant order F, D, F, D; no done pulse overlaps; busy low exactly one cycle between transactions.
- rst pulsed during WAIT -> all outputs 0 in the same cycle, no done pulse; after release with no reqs, stays IDLE with busy=0.
- MEM_LAT=1 build, data read of 0x05 returning 0x77 -> d_done in cycle 3, d_rdata=0x77.
